uart_cmd_decoder: RTL and testbench

Host-to-board command path, the reverse direction of the temperature/alarm telemetry sent through uart_send. It consumes the byte stream from uart_recv (done strobe + data) and parses fixed 6-byte frames. Valid frames emit set-time, set-alarm or set-temperature-limit updates to the clock/alarm logic. Each accepted frame is answered with a single ACK or NAK byte through the uart_send handshake.

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_byte_timeout.sv | 33 +++
 rtl/uart_cmd_decoder.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the host command decoder: frame marker, command codes,
// response bytes, field limits, reset values and FSM encoding.
package uart_cmd_pkg;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CMD_SET_TIME  = 8'h01;
  localparam logic [7:0] CMD_SET_ALARM = 8'h02;
  localparam logic [7:0] CMD_SET_LIMIT = 8'h03;
  localparam logic [7:0] ACK_BYTE      = 8'h06;
  localparam logic [7:0] NAK_BYTE      = 8'h15;
  localparam logic [7:0] HOUR_MAX      = 8'd23;
  localparam logic [7:0] MIN_MAX       = 8'd59;
  localparam logic [7:0] SEC_MAX       = 8'd59;
  localparam logic [7:0] LIMIT_MAX     = 8'd127;
  localparam logic [7:0] ALARM_MIN_RST = 8'd5;
  localparam logic [7:0] TEM_LIMIT_RST = 8'd35;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GET_CMD, ST_GET_P0, ST_GET_P1,
    ST_GET_P2, ST_GET_CHK, ST_EXEC, ST_ACK_WAIT
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] p0,
                                           input logic [7:0] p1, input logic [7:0] p2);
    return cmd ^ p0 ^ p1 ^ p2;
  endfunction
endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags the LIMIT-th one. A clear in that same cycle suppresses the flag.
module uart_byte_timeout #(
  parameter int LIMIT = 120000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_o = 1'b0;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == W'(LIMIT - 1)) begin
      expired_o = 1'b1;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 6-byte host frames (SYNC CMD P0 P1 P2 CHK), applies time/alarm/limit
// updates and answers each complete frame with one ACK or NAK byte.
// Handshake: uart_done qualifies uart_data for exactly one cycle; ack_en is a
// one-cycle request issued only in a cycle after uart_tx_busy was seen low.
module uart_cmd_decoder import uart_cmd_pkg::*; #(
  parameter int          CLK_FREQ   = 12000000,
  parameter int          TIMEOUT_MS = 10,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  input  logic       uart_tx_busy,
  output logic       ack_en,
  output logic [7:0] ack_data,
  output logic       time_set_pulse,
  output logic [7:0] set_hour,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic       alarm_set_pulse,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic       tem_limit_pulse,
  output logic [7:0] tem_limit,
  output logic       frame_err,
  output logic [2:0] dbg_state_o
);
  localparam int LIMIT = CLK_FREQ / 1000 * TIMEOUT_MS;

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d, p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0] ahour_q, ahour_d, amin_q, amin_d, limit_q, limit_d;
  logic [7:0] ack_data_q, ack_data_d;
  logic       ack_en_q, ack_en_d, tpulse_q, tpulse_d, apulse_q, apulse_d;
  logic       lpulse_q, lpulse_d, ferr_q, ferr_d;
  logic       in_frame, expired, fields_ok, frame_ok;

  assign in_frame = (state_q == ST_GET_CMD) || (state_q == ST_GET_P0) ||
                    (state_q == ST_GET_P1)  || (state_q == ST_GET_P2) ||
                    (state_q == ST_GET_CHK);

  uart_byte_timeout #(.LIMIT(LIMIT)) u_timeout (
    .clk_i     (sys_clk),
    .rst_n_i   (sys_rst_n),
    .clr_i     (uart_done),
    .en_i      (in_frame),
    .expired_o (expired)
  );

  always_comb begin
    fields_ok = 1'b0;
    case (cmd_q)
      CMD_SET_TIME:  fields_ok = (p0_q <= HOUR_MAX) && (p1_q <= MIN_MAX) && (p2_q <= SEC_MAX);
      CMD_SET_ALARM: fields_ok = (p0_q <= HOUR_MAX) && (p1_q <= MIN_MAX);
      CMD_SET_LIMIT: fields_ok = (p0_q <= LIMIT_MAX);
      default:       fields_ok = 1'b0;
    endcase
  end

  // Evaluated while the CHK byte is on uart_data, so results land in EXEC.
  assign frame_ok = fields_ok && (frame_chk(cmd_q, p0_q, p1_q, p2_q) == uart_data);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    ahour_d    = ahour_q;
    amin_d     = amin_q;
    limit_d    = limit_q;
    ack_data_d = ack_data_q;
    ack_en_d   = 1'b0;
    tpulse_d   = 1'b0;
    apulse_d   = 1'b0;
    lpulse_d   = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      ST_IDLE: if (uart_done && uart_data == SYNC_BYTE) state_d = ST_GET_CMD;
      ST_GET_CMD, ST_GET_P0, ST_GET_P1, ST_GET_P2, ST_GET_CHK: begin
        if (uart_done) begin
          case (state_q)
            ST_GET_CMD: begin cmd_d = uart_data; state_d = ST_GET_P0;  end
            ST_GET_P0:  begin p0_d  = uart_data; state_d = ST_GET_P1;  end
            ST_GET_P1:  begin p1_d  = uart_data; state_d = ST_GET_P2;  end
            ST_GET_P2:  begin p2_d  = uart_data; state_d = ST_GET_CHK; end
            default: begin
              state_d    = ST_EXEC;
              ack_data_d = frame_ok ? ACK_BYTE : NAK_BYTE;
              if (frame_ok) begin
                case (cmd_q)
                  CMD_SET_TIME:  begin hour_d = p0_q; min_d = p1_q; sec_d = p2_q; tpulse_d = 1'b1; end
                  CMD_SET_ALARM: begin ahour_d = p0_q; amin_d = p1_q; apulse_d = 1'b1; end
                  default:       begin limit_d = p0_q; lpulse_d = 1'b1; end
                endcase
              end
            end
          endcase
        end else if (expired) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_ACK_WAIT;
      ST_ACK_WAIT: begin
        if (!uart_tx_busy) begin
          ack_en_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      p0_q       <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      ahour_q    <= '0;
      amin_q     <= ALARM_MIN_RST;
      limit_q    <= TEM_LIMIT_RST;
      ack_data_q <= '0;
      ack_en_q   <= 1'b0;
      tpulse_q   <= 1'b0;
      apulse_q   <= 1'b0;
      lpulse_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      ahour_q    <= ahour_d;
      amin_q     <= amin_d;
      limit_q    <= limit_d;
      ack_data_q <= ack_data_d;
      ack_en_q   <= ack_en_d;
      tpulse_q   <= tpulse_d;
      apulse_q   <= apulse_d;
      lpulse_q   <= lpulse_d;
      ferr_q     <= ferr_d;
    end
  end

  assign ack_en          = ack_en_q;
  assign ack_data        = ack_data_q;
  assign time_set_pulse  = tpulse_q;
  assign set_hour        = hour_q;
  assign set_min         = min_q;
  assign set_sec         = sec_q;
  assign alarm_set_pulse = apulse_q;
  assign alarm_hour      = ahour_q;
  assign alarm_min       = amin_q;
  assign tem_limit_pulse = lpulse_q;
  assign tem_limit       = limit_q;
  assign frame_err       = ferr_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: table of directed frames, randomized frames
// judged by a frame-level model, and hand sequences for timeout/busy/reset.
module tb_uart_cmd_decoder;
  localparam int CLK_FREQ   = 1_000_000;
  localparam int TIMEOUT_MS = 1;
  localparam int LIMIT      = CLK_FREQ / 1000 * TIMEOUT_MS;

  typedef logic [47:0] frame_t;
  // kind: 0 rejected, 1 set time, 2 set alarm, 3 set limit
  typedef struct {
    frame_t     f;
    logic [7:0] ack;
    int         kind;
  } vec_t;

  logic       sys_clk, sys_rst_n, uart_done, uart_tx_busy;
  logic [7:0] uart_data;
  logic       ack_en, time_set_pulse, alarm_set_pulse, tem_limit_pulse, frame_err;
  logic [7:0] ack_data, set_hour, set_min, set_sec, alarm_hour, alarm_min, tem_limit;
  logic [2:0] dbg_state;

  uart_cmd_decoder #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .uart_done       (uart_done),
    .uart_data       (uart_data),
    .uart_tx_busy    (uart_tx_busy),
    .ack_en          (ack_en),
    .ack_data        (ack_data),
    .time_set_pulse  (time_set_pulse),
    .set_hour        (set_hour),
    .set_min         (set_min),
    .set_sec         (set_sec),
    .alarm_set_pulse (alarm_set_pulse),
    .alarm_hour      (alarm_hour),
    .alarm_min       (alarm_min),
    .tem_limit_pulse (tem_limit_pulse),
    .tem_limit       (tem_limit),
    .frame_err       (frame_err),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state
  int n_checks = 0, n_pass = 0;
  int ack_cnt = 0, fe_cnt = 0, tp_cnt = 0, ap_cnt = 0, lp_cnt = 0;
  int exp_tp = 0, exp_ap = 0, exp_lp = 0, exp_fe = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_hour = 0, m_min = 0, m_sec = 0, m_ahour = 0, m_amin = 5, m_lim = 35;
  logic ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor samples 3 time units after each rising edge.
  always begin
    @(posedge sys_clk);
    #3;
    if (ack_en === 1'b1) begin
      check("ack_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("ack_data", 32'(ack_data), 32'(exp_q.pop_front()));
      check("ack_single_cycle", 32'(ack_prev), 0);
      ack_cnt++;
    end
    ack_prev = (ack_en === 1'b1);
    if (frame_err === 1'b1)       fe_cnt++;
    if (time_set_pulse === 1'b1)  tp_cnt++;
    if (alarm_set_pulse === 1'b1) ap_cnt++;
    if (tem_limit_pulse === 1'b1) lp_cnt++;
  end

  // ---------------- reference model (frame level)
  function automatic logic [7:0] byte_at(input frame_t f, input int i);
    return f[47-8*i -: 8];
  endfunction

  function automatic void judge(input frame_t f, output logic [7:0] ack, output int kind);
    int c, h, m, s;
    bit ok;
    c = int'(byte_at(f, 1));
    h = int'(byte_at(f, 2));
    m = int'(byte_at(f, 3));
    s = int'(byte_at(f, 4));
    ok = ((byte_at(f, 1) ^ byte_at(f, 2) ^ byte_at(f, 3) ^ byte_at(f, 4)) == byte_at(f, 5));
    kind = 0;
    if (ok) begin
      if (c == 1 && h < 24 && m < 60 && s < 60) kind = 1;
      else if (c == 2 && h < 24 && m < 60)      kind = 2;
      else if (c == 3 && h < 128)               kind = 3;
    end
    ack = (kind != 0) ? 8'h06 : 8'h15;
  endfunction

  task automatic model_update(input frame_t f, input int kind);
    case (kind)
      1: begin m_hour = byte_at(f, 2); m_min = byte_at(f, 3); m_sec = byte_at(f, 4); exp_tp++; end
      2: begin m_ahour = byte_at(f, 2); m_amin = byte_at(f, 3); exp_ap++; end
      3: begin m_lim = byte_at(f, 2); exp_lp++; end
      default: ;
    endcase
  endtask

  task automatic check_values();
    check("set_hour",   32'(set_hour),   32'(m_hour));
    check("set_min",    32'(set_min),    32'(m_min));
    check("set_sec",    32'(set_sec),    32'(m_sec));
    check("alarm_hour", 32'(alarm_hour), 32'(m_ahour));
    check("alarm_min",  32'(alarm_min),  32'(m_amin));
    check("tem_limit",  32'(tem_limit),  32'(m_lim));
  endtask

  // ---------------- driver tasks (called at a falling edge, return at one)
  task automatic send_byte(input logic [7:0] b, input int idle);
    uart_done = 1'b1;
    uart_data = b;
    @(negedge sys_clk);
    uart_done = 1'b0;
    repeat (idle) @(negedge sys_clk);
  endtask

  task automatic send_raw(input frame_t f, input int gap);
    for (int i = 0; i < 5; i++) send_byte(byte_at(f, i), gap - 1);
    send_byte(byte_at(f, 5), 0);
  endtask

  task automatic apply_frame(input frame_t f, input logic [7:0] ack, input int kind,
                             input int gap, input int busy_cycles);
    int base, t;
    model_update(f, kind);
    if (busy_cycles > 0) uart_tx_busy = 1'b1;
    send_raw(f, gap);
    base = ack_cnt;
    check("time_pulse",  32'(time_set_pulse),  32'(kind == 1));
    check("alarm_pulse", 32'(alarm_set_pulse), 32'(kind == 2));
    check("limit_pulse", 32'(tem_limit_pulse), 32'(kind == 3));
    check("ack_not_in_exec", 32'(ack_en), 0);
    check_values();
    exp_q.push_back(ack);
    if (busy_cycles > 0) begin
      repeat (busy_cycles) @(negedge sys_clk);
      check("ack_held_by_busy", 32'(ack_cnt - base), 0);
      uart_tx_busy = 1'b0;
    end
    t = 0;
    while (ack_cnt == base && t < 50) begin
      @(negedge sys_clk);
      t++;
    end
    check("ack_seen", 32'(ack_cnt - base), 1);
    @(negedge sys_clk);
    check("ack_dropped", 32'(ack_en), 0);
  endtask

  task automatic check_reset_values();
    check("rst_ack_en",      32'(ack_en), 0);
    check("rst_ack_data",    32'(ack_data), 0);
    check("rst_time_pulse",  32'(time_set_pulse), 0);
    check("rst_alarm_pulse", 32'(alarm_set_pulse), 0);
    check("rst_limit_pulse", 32'(tem_limit_pulse), 0);
    check("rst_frame_err",   32'(frame_err), 0);
    check("rst_state",       32'(dbg_state), 0);
    check_values();
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    m_hour = 0; m_min = 0; m_sec = 0; m_ahour = 0; m_amin = 5; m_lim = 35;
    #1;
    check_reset_values();
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic run_random(input int n);
    logic [7:0] c, p0, p1, p2, k, j, a;
    frame_t f;
    int kd;
    for (int r = 0; r < n; r++) begin
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h00;
        send_byte(j, int'($urandom_range(0, 3)));
      end
      c  = 8'($urandom_range(0, 4));
      p0 = (c == 8'h03) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
      p1 = 8'($urandom_range(0, 70));
      p2 = 8'($urandom_range(0, 70));
      k  = c ^ p0 ^ p1 ^ p2;
      if ($urandom_range(0, 7) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
      f = {8'hA5, c, p0, p1, p2, k};
      judge(f, a, kd);
      apply_frame(f, a, kd, int'($urandom_range(1, 4)),
                  int'($urandom_range(0, 1) * $urandom_range(1, 6)));
    end
  endtask

  // ---------------- main sequence
  vec_t vecs[11];

  initial begin
    int base, fe_base;
    sys_rst_n = 1'b0; uart_done = 1'b0; uart_data = 8'h00; uart_tx_busy = 1'b0;
    vecs[0]  = '{48'hA5010C223817, 8'h06, 1};  // 12:34:56
    vecs[1]  = '{48'hA502071E001B, 8'h06, 2};  // alarm 07:30
    vecs[2]  = '{48'hA5032800002B, 8'h06, 3};  // limit 40
    vecs[3]  = '{48'hA5010C223818, 8'h15, 0};  // bad checksum
    vecs[4]  = '{48'hA50118223803, 8'h15, 0};  // hour 24
    vecs[5]  = '{48'hA501173B3B16, 8'h06, 1};  // 23:59:59
    vecs[6]  = '{48'hA501003C003D, 8'h15, 0};  // minute 60
    vecs[7]  = '{48'hA5037F00007C, 8'h06, 3};  // limit 127
    vecs[8]  = '{48'hA50380000083, 8'h15, 0};  // limit 128
    vecs[9]  = '{48'hA50401020304, 8'h15, 0};  // unknown command
    vecs[10] = '{48'hA50310A500B6, 8'h06, 3};  // sync value inside payload

    repeat (3) @(negedge sys_clk);
    check_reset_values();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 11; i++) apply_frame(vecs[i].f, vecs[i].ack, vecs[i].kind, 1 + (i % 3), 0);

    // Junk then a stalled partial frame: exactly one timeout, no response.
    base = ack_cnt; fe_base = fe_cnt;
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'hA5, 0);
    send_byte(8'h01, 0); send_byte(8'h0C, 0);
    repeat (LIMIT + 20) @(negedge sys_clk);
    exp_fe++;
    check("timeout_frame_err", 32'(fe_cnt - fe_base), 1);
    check("timeout_state_idle", 32'(dbg_state), 0);
    check("timeout_no_ack", 32'(ack_cnt - base), 0);
    apply_frame(vecs[0].f, vecs[0].ack, vecs[0].kind, 1, 0);

    // Gap of exactly LIMIT cycles is still accepted.
    fe_base = fe_cnt;
    apply_frame(vecs[1].f, vecs[1].ack, vecs[1].kind, LIMIT, 0);
    check("gap_limit_no_err", 32'(fe_cnt - fe_base), 0);

    // One cycle longer aborts; the trailing bytes are ignored in IDLE.
    base = ack_cnt; fe_base = fe_cnt;
    send_byte(8'hA5, LIMIT);
    for (int i = 1; i < 6; i++) send_byte(byte_at(vecs[0].f, i), 0);
    repeat (10) @(negedge sys_clk);
    exp_fe++;
    check("gap_over_frame_err", 32'(fe_cnt - fe_base), 1);
    check("gap_over_no_ack", 32'(ack_cnt - base), 0);

    // Busy held across EXEC.
    apply_frame(vecs[2].f, vecs[2].ack, vecs[2].kind, 1, 50);

    // Reset after P1, then a valid frame.
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h0C, 0); send_byte(8'h22, 0);
    do_reset();
    apply_frame(vecs[0].f, vecs[0].ack, vecs[0].kind, 1, 0);

    // Reset while the ACK is pending: it must be discarded.
    uart_tx_busy = 1'b1;
    send_raw(vecs[7].f, 1);
    exp_lp++;
    repeat (3) @(negedge sys_clk);
    base = ack_cnt;
    do_reset();
    uart_tx_busy = 1'b0;
    repeat (20) @(negedge sys_clk);
    check("reset_discards_ack", 32'(ack_cnt - base), 0);
    apply_frame(vecs[1].f, vecs[1].ack, vecs[1].kind, 2, 0);

    run_random(30);

    repeat (5) @(negedge sys_clk);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("time_pulse_count",  32'(tp_cnt), 32'(exp_tp));
    check("alarm_pulse_count", 32'(ap_cnt), 32'(exp_ap));
    check("limit_pulse_count", 32'(lp_cnt), 32'(exp_lp));
    check("frame_err_count",   32'(fe_cnt), 32'(exp_fe));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
